// File: rtl/clock_gate_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_gate_pkg
//  Description : Shared state encoding, widths and helpers for the
//                clock-gating enable controller.
//  Revision    : 1.0  initial release
// ============================================================================
package clock_gate_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_SLEEP_REQ = 2'd1,
    ST_GATED     = 2'd2,
    ST_WAKE      = 2'd3
  } state_t;

  // Width of the gated-cycle statistics counter
  localparam int STATS_W = 32;

  // Bits needed to hold values 0..max_val (at least one bit)
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cg_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : cg_sat_counter
//  Description : Up-counter with synchronous clear and saturation at MAX_VAL.
//                Clear has priority over increment.
//  Revision    : 1.0  initial release
// ============================================================================
module cg_sat_counter #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Clear wins; otherwise count up and hold at MAX_VAL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_VAL)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/clock_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clock_gate_ctrl
//  Description : Enable controller for an integrated clock-gating cell.
//                Detects idle time in the gated domain, negotiates sleep
//                with a req/ack handshake, drops cg_en, and restores the
//                clock on wake, reporting clk_ready once settled.
//                Optional macro CLOCK_GATE_STATS_EN adds stats_clr and a
//                32-bit saturating gated_cycles counter.
//  Revision    : 1.0  initial release
// ============================================================================
module clock_gate_ctrl
  import clock_gate_pkg::*;
#(
  parameter int IDLE_CYCLES = 16,
  parameter int ACK_TIMEOUT = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic test_mode,
  input  logic busy,
  input  logic wake_req,
  input  logic sleep_ack,
  output logic sleep_req,
  output logic cg_en,
  output logic cg_te,
  output logic clk_ready
`ifdef CLOCK_GATE_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [STATS_W-1:0] gated_cycles
`endif
);

  localparam int IDLE_W = cnt_width(IDLE_CYCLES);
  localparam int TMO_W  = cnt_width(ACK_TIMEOUT);
  localparam int WK_W   = cnt_width(WAKE_CYCLES);

  localparam logic [IDLE_W-1:0] C_IDLE_MAX  = IDLE_W'(IDLE_CYCLES);
  localparam logic [IDLE_W-1:0] C_IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [TMO_W-1:0]  C_TMO_MAX   = TMO_W'(ACK_TIMEOUT);
  localparam logic [TMO_W-1:0]  C_TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [WK_W-1:0]   C_WK_MAX    = WK_W'(WAKE_CYCLES);
  localparam logic [WK_W-1:0]   C_WK_LAST   = WK_W'(WAKE_CYCLES - 1);

  state_t r_state;

  logic              w_idle;
  logic              w_wake;
  logic [IDLE_W-1:0] w_idle_cnt;
  logic [TMO_W-1:0]  w_tmo_cnt;
  logic [WK_W-1:0]   w_wk_cnt;

  // TE is a pure passthrough so scan can override gating immediately
  assign cg_te  = test_mode;
  assign w_wake = busy | wake_req;
  assign w_idle = ~w_wake;

  // Each counter is held at zero outside the state that uses it, so it
  // always starts from zero on entry to that state.
  cg_sat_counter #(.WIDTH(IDLE_W), .MAX_VAL(C_IDLE_MAX)) u_idle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (test_mode | (r_state != ST_RUN) | ~w_idle),
    .inc   ((r_state == ST_RUN) & w_idle),
    .count (w_idle_cnt)
  );

  cg_sat_counter #(.WIDTH(TMO_W), .MAX_VAL(C_TMO_MAX)) u_tmo_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (test_mode | (r_state != ST_SLEEP_REQ)),
    .inc   (r_state == ST_SLEEP_REQ),
    .count (w_tmo_cnt)
  );

  cg_sat_counter #(.WIDTH(WK_W), .MAX_VAL(C_WK_MAX)) u_wk_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (test_mode | (r_state != ST_WAKE)),
    .inc   (r_state == ST_WAKE),
    .count (w_wk_cnt)
  );

`ifdef CLOCK_GATE_STATS_EN
  cg_sat_counter #(.WIDTH(STATS_W), .MAX_VAL('1)) u_gated_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stats_clr),
    .inc   (r_state == ST_GATED),
    .count (gated_cycles)
  );
`endif

  // Sleep/wake sequencing; cg_en is a flop so the ICG E pin never glitches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      cg_en     <= 1'b1;
      sleep_req <= 1'b0;
      clk_ready <= 1'b1;
    end else if (test_mode) begin
      r_state   <= ST_RUN;
      cg_en     <= 1'b1;
      sleep_req <= 1'b0;
      clk_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_idle && (w_idle_cnt == C_IDLE_LAST)) begin
            r_state   <= ST_SLEEP_REQ;
            sleep_req <= 1'b1;
          end
        end
        ST_SLEEP_REQ: begin
          // New work or wake beats a simultaneous ack
          if (w_wake) begin
            r_state   <= ST_RUN;
            sleep_req <= 1'b0;
          end else if (sleep_ack) begin
            r_state   <= ST_GATED;
            cg_en     <= 1'b0;
            clk_ready <= 1'b0;
          end else if (w_tmo_cnt == C_TMO_LAST) begin
            r_state   <= ST_RUN;
            sleep_req <= 1'b0;
          end
        end
        ST_GATED: begin
          if (w_wake) begin
            r_state   <= ST_WAKE;
            cg_en     <= 1'b1;
            sleep_req <= 1'b0;
          end
        end
        ST_WAKE: begin
          // Hold off until the domain has released its ack
          if ((w_wk_cnt >= C_WK_LAST) && !sleep_ack) begin
            r_state   <= ST_RUN;
            clk_ready <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_RUN;
          cg_en     <= 1'b1;
          sleep_req <= 1'b0;
          clk_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_gate_ctrl
//  Description : Directed self-checking bench for clock_gate_ctrl with
//                IDLE_CYCLES=4, ACK_TIMEOUT=3, WAKE_CYCLES=2.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clock_gate_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic test_mode;
  logic busy;
  logic wake_req;
  logic sleep_ack;
  logic sleep_req;
  logic cg_en;
  logic cg_te;
  logic clk_ready;
`ifdef CLOCK_GATE_STATS_EN
  logic        stats_clr;
  logic [31:0] gated_cycles;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  clock_gate_ctrl #(
    .IDLE_CYCLES (4),
    .ACK_TIMEOUT (3),
    .WAKE_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .test_mode (test_mode),
    .busy      (busy),
    .wake_req  (wake_req),
    .sleep_ack (sleep_ack),
    .sleep_req (sleep_req),
    .cg_en     (cg_en),
    .cg_te     (cg_te),
    .clk_ready (clk_ready)
`ifdef CLOCK_GATE_STATS_EN
    ,
    .stats_clr    (stats_clr),
    .gated_cycles (gated_cycles)
`endif
  );

  // Count one comparison and report it if it does not match
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock, then settle just past the edge
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Walk n idle edges expecting no request, then one more expecting it
  task automatic idle_to_req(input string tag, input int n);
    step(n);
    check({tag, "_pre"}, {31'd0, sleep_req}, 32'd0);
    step(1);
    check({tag, "_req"}, {31'd0, sleep_req}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    test_mode = 1'b0;
    busy      = 1'b0;
    wake_req  = 1'b0;
    sleep_ack = 1'b0;
`ifdef CLOCK_GATE_STATS_EN
    stats_clr = 1'b0;
`endif
    step(2);
    check("rst_cg_en",     {31'd0, cg_en},     32'd1);
    check("rst_clk_ready", {31'd0, clk_ready}, 32'd1);
    check("rst_sleep_req", {31'd0, sleep_req}, 32'd0);
    check("rst_cg_te",     {31'd0, cg_te},     32'd0);
    rst_n = 1'b1;

    // Fourth idle edge after release raises sleep_req
    idle_to_req("first", 3);

    // Ack never comes: request held for 3 cycles then dropped
    step(2);
    check("tmo_hold", {31'd0, sleep_req}, 32'd1);
    step(1);
    check("tmo_drop", {31'd0, sleep_req}, 32'd0);
    check("tmo_cg_en", {31'd0, cg_en}, 32'd1);
    idle_to_req("after_tmo", 3);

    // Full sleep: ack one cycle after request
    sleep_ack = 1'b1;
    step(1);
    check("gate_cg_en",     {31'd0, cg_en},     32'd0);
    check("gate_clk_ready", {31'd0, clk_ready}, 32'd0);
    check("gate_sleep_req", {31'd0, sleep_req}, 32'd1);
    step(2);
    check("gate_stay", {31'd0, cg_en}, 32'd0);
    wake_req  = 1'b1;
    sleep_ack = 1'b0;
    step(1);
    wake_req  = 1'b0;
    check("wake_cg_en",     {31'd0, cg_en},     32'd1);
    check("wake_sleep_req", {31'd0, sleep_req}, 32'd0);
    check("wake_not_ready", {31'd0, clk_ready}, 32'd0);
    step(1);
    check("wake_not_ready2", {31'd0, clk_ready}, 32'd0);
    step(1);
    check("wake_ready", {31'd0, clk_ready}, 32'd1);
`ifdef CLOCK_GATE_STATS_EN
    check("stats_cnt", gated_cycles, 32'd3);
    busy      = 1'b1;
    stats_clr = 1'b1;
    step(1);
    stats_clr = 1'b0;
    busy      = 1'b0;
    check("stats_clr", gated_cycles, 32'd0);
`endif

    // Race: wake and ack together while requesting -> back to RUN
    idle_to_req("race", 3);
    wake_req  = 1'b1;
    sleep_ack = 1'b1;
    step(1);
    wake_req  = 1'b0;
    sleep_ack = 1'b0;
    check("race_sleep_req", {31'd0, sleep_req}, 32'd0);
    check("race_cg_en",     {31'd0, cg_en},     32'd1);
    check("race_ready",     {31'd0, clk_ready}, 32'd1);

    // Busy glitch at idle_cnt=3 restarts the idle count
    step(3);
    check("glitch_pre", {31'd0, sleep_req}, 32'd0);
    busy = 1'b1;
    step(1);
    busy = 1'b0;
    check("glitch_busy", {31'd0, sleep_req}, 32'd0);
    idle_to_req("glitch", 3);

    // Ack held through WAKE delays clk_ready
    sleep_ack = 1'b1;
    step(1);
    check("hold_gated", {31'd0, cg_en}, 32'd0);
    wake_req = 1'b1;
    step(1);
    wake_req = 1'b0;
    check("hold_wake_cg_en", {31'd0, cg_en}, 32'd1);
    step(2);
    check("hold_not_ready", {31'd0, clk_ready}, 32'd0);
    sleep_ack = 1'b0;
    step(1);
    check("hold_ready", {31'd0, clk_ready}, 32'd1);
`ifdef CLOCK_GATE_STATS_EN
    check("stats_cnt2", gated_cycles, 32'd1);
`endif

    // Test mode while gated
    idle_to_req("tm", 3);
    sleep_ack = 1'b1;
    step(1);
    check("tm_gated", {31'd0, cg_en}, 32'd0);
    test_mode = 1'b1;
    #1;
    check("tm_cg_te",      {31'd0, cg_te}, 32'd1);
    check("tm_cg_en_wait", {31'd0, cg_en}, 32'd0);
    step(1);
    check("tm_cg_en",     {31'd0, cg_en},     32'd1);
    check("tm_ready",     {31'd0, clk_ready}, 32'd1);
    check("tm_sleep_req", {31'd0, sleep_req}, 32'd0);
    test_mode = 1'b0;
    sleep_ack = 1'b0;
    idle_to_req("after_tm", 3);

    // Asynchronous reset while gated
    sleep_ack = 1'b1;
    step(1);
    check("ar_gated", {31'd0, cg_en}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_cg_en",     {31'd0, cg_en},     32'd1);
    check("ar_sleep_req", {31'd0, sleep_req}, 32'd0);
    check("ar_ready",     {31'd0, clk_ready}, 32'd1);
`ifdef CLOCK_GATE_STATS_EN
    check("ar_stats", gated_cycles, 32'd0);
`endif
    sleep_ack = 1'b0;
    step(1);
    rst_n = 1'b1;
    idle_to_req("after_ar", 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
